// File: rtl/seq_tx.sv
// Serial pattern transmitter. It shifts out a parallel word MSB-first (for the selected length)
// and counts the overlapping 101 and 100 windows in the emitted stream.
module seq_tx #(
    parameter int W  = 42,
    parameter int LW = 6,
    parameter int CW = 6
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [W-1:0]  data,
    input  logic [LW-1:0] len,
    output logic          x,
    output logic          valid,
    output logic          busy,
    output logic          done,
    output logic [CW-1:0] cnt101,
    output logic [CW-1:0] cnt100
);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        FIN
    } state_t;

    localparam logic [LW-1:0] WMAX = LW'(W);

    state_t        state;
    logic [W-1:0]  sreg;
    logic [LW-1:0] remaining;
    logic [1:0]    hist;
    logic [1:0]    seen;

    logic [LW-1:0] len_c;
    logic [LW-1:0] rem_dec;
    logic [W-1:0]  aligned;
    logic [W-1:0]  sreg_next;
    logic          cur;
    logic [2:0]    window;

    // The word is left-aligned on accept, so bit remaining-1 always sits at the MSB.
    // This avoids a variable index into the shift register.
    always_comb begin
        len_c     = (len > WMAX) ? WMAX : len;
        aligned   = data << (WMAX - len_c);
        rem_dec   = remaining - LW'(1);
        sreg_next = sreg << 1;
        cur       = sreg[W-1];
        window    = {hist, cur};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            sreg      <= '0;
            remaining <= '0;
            hist      <= '0;
            seen      <= '0;
            x         <= 1'b0;
            valid     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            cnt101    <= '0;
            cnt100    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        sreg      <= aligned;
                        remaining <= len_c;
                        hist      <= '0;
                        seen      <= '0;
                        cnt101    <= '0;
                        cnt100    <= '0;
                        busy      <= 1'b1;
                        if (len_c != '0) begin
                            state <= SHIFT;
                            x     <= aligned[W-1];
                            valid <= 1'b1;
                        end else begin
                            state <= FIN;
                            done  <= 1'b1;
                        end
                    end
                end
                SHIFT: begin
                    sreg      <= sreg_next;
                    remaining <= rem_dec;
                    hist      <= {hist[0], cur};
                    if (seen != 2'd2) begin
                        seen <= seen + 2'd1;
                    end else begin
                        if (window == 3'b101 && cnt101 != '1) cnt101 <= cnt101 + CW'(1);
                        if (window == 3'b100 && cnt100 != '1) cnt100 <= cnt100 + CW'(1);
                    end
                    if (rem_dec == '0) begin
                        state <= FIN;
                        x     <= 1'b0;
                        valid <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        x <= sreg_next[W-1];
                    end
                end
                FIN: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_tx.sv
// Bench for seq_tx: two instances (the default build and a narrow build that exercises clamping and
// saturation) checked every cycle against a stream-level reference model, plus directed literal checks.
module tb_seq_tx;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_a, start_b;
    logic [41:0] data_a;
    logic [11:0] data_b;
    logic [5:0]  len_a, len_b;
    logic        x_a, valid_a, busy_a, done_a;
    logic        x_b, valid_b, busy_b, done_b;
    logic [5:0]  c101_a, c100_a;
    logic [1:0]  c101_b, c100_b;

    int vectors     = 0;
    int miscompares = 0;
    bit armed       = 0;

    always #5 clk = ~clk;

    seq_tx #(.W(42), .LW(6), .CW(6)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .data(data_a), .len(len_a),
        .x(x_a), .valid(valid_a), .busy(busy_a), .done(done_a),
        .cnt101(c101_a), .cnt100(c100_a)
    );

    seq_tx #(.W(12), .LW(6), .CW(2)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .data(data_b), .len(len_b),
        .x(x_b), .valid(valid_b), .busy(busy_b), .done(done_b),
        .cnt101(c101_b), .cnt100(c100_b)
    );

    typedef struct {
        logic x;
        logic v;
        logic b;
        logic d;
        bit   chk;
        int   c1;
        int   c0;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    int   last1[2];
    int   last0[2];

    task automatic cmp(input string nm, input int w, input int act, input int expv);
        vectors++;
        if (act != expv) begin
            miscompares++;
            $display("FAIL %s dut%0d t=%0t got %0d want %0d", nm, w, $time, act, expv);
        end
    endtask

    // Expand one accepted request into its per-cycle expected outputs.
    task automatic push_stream(input int w, input logic [63:0] d, input int l_raw);
        int   wmax, cmax, len, c1, c0;
        logic b0, b1, b2;
        exp_t e;
        wmax = (w == 0) ? 42 : 12;
        cmax = (w == 0) ? 63 : 3;
        len  = (l_raw > wmax) ? wmax : l_raw;
        c1   = 0;
        c0   = 0;
        for (int k = 0; k < len; k++) begin
            e = '{x: d[len-1-k], v: 1'b1, b: 1'b1, d: 1'b0, chk: 1'b0, c1: 0, c0: 0};
            if (w == 0) qa.push_back(e); else qb.push_back(e);
            if (k >= 2) begin
                b0 = d[len-1-(k-2)];
                b1 = d[len-1-(k-1)];
                b2 = d[len-1-k];
                if ({b0, b1, b2} == 3'b101) c1++;
                if ({b0, b1, b2} == 3'b100) c0++;
            end
        end
        if (c1 > cmax) c1 = cmax;
        if (c0 > cmax) c0 = cmax;
        e = '{x: 1'b0, v: 1'b0, b: 1'b1, d: 1'b1, chk: 1'b1, c1: c1, c0: c0};
        if (w == 0) qa.push_back(e); else qb.push_back(e);
        last1[w] = c1;
        last0[w] = c0;
    endtask

    always @(posedge clk) begin
        if (rst) begin
            qa.delete();
            qb.delete();
            last1 = '{0, 0};
            last0 = '{0, 0};
            armed = 1;
        end else begin
            if (qa.size() == 0) begin
                if (start_a) push_stream(0, 64'(data_a), int'(len_a));
            end else begin
                void'(qa.pop_front());
            end
            if (qb.size() == 0) begin
                if (start_b) push_stream(1, 64'(data_b), int'(len_b));
            end else begin
                void'(qb.pop_front());
            end
        end
    end

    task automatic check(input int w);
        exp_t e;
        logic ax, av, ab, ad;
        int   a1, a0;
        if (w == 0) begin
            {ax, av, ab, ad} = {x_a, valid_a, busy_a, done_a};
            a1 = int'(c101_a);
            a0 = int'(c100_a);
            if (qa.size() > 0) e = qa[0];
            else e = '{x: 1'b0, v: 1'b0, b: 1'b0, d: 1'b0, chk: 1'b1, c1: last1[0], c0: last0[0]};
        end else begin
            {ax, av, ab, ad} = {x_b, valid_b, busy_b, done_b};
            a1 = int'(c101_b);
            a0 = int'(c100_b);
            if (qb.size() > 0) e = qb[0];
            else e = '{x: 1'b0, v: 1'b0, b: 1'b0, d: 1'b0, chk: 1'b1, c1: last1[1], c0: last0[1]};
        end
        cmp("x", w, int'(ax), int'(e.x));
        cmp("valid", w, int'(av), int'(e.v));
        cmp("busy", w, int'(ab), int'(e.b));
        cmp("done", w, int'(ad), int'(e.d));
        if (e.chk) begin
            cmp("cnt101", w, a1, e.c1);
            cmp("cnt100", w, a0, e.c0);
        end
    endtask

    always @(negedge clk) begin
        if (armed) begin
            check(0);
            check(1);
        end
    end

    task automatic drive(input int w, input logic s, input logic [63:0] d, input int l);
        if (w == 0) begin
            start_a = s;
            data_a  = d[41:0];
            len_a   = l[5:0];
        end else begin
            start_b = s;
            data_b  = d[11:0];
            len_b   = l[5:0];
        end
    endtask

    task automatic go(input int w, input logic [63:0] d, input int l, input bit extra,
                      output logic [63:0] bits, output int nb, output int dn,
                      output int c1, output int c0);
        logic v, xx, dd;
        @(negedge clk);
        drive(w, 1'b1, d, l);
        @(negedge clk);
        drive(w, 1'b0, d, l);
        bits = '0;
        nb   = 0;
        dn   = -1;
        c1   = -1;
        c0   = -1;
        for (int n = 1; n <= 200; n++) begin
            if (extra && n == 3) drive(w, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 40);
            if (extra && n == 4) drive(w, 1'b0, d, l);
            v  = (w == 0) ? valid_a : valid_b;
            xx = (w == 0) ? x_a : x_b;
            dd = (w == 0) ? done_a : done_b;
            if (v) begin
                bits = {bits[62:0], xx};
                nb++;
            end
            if (dd) begin
                dn = n;
                c1 = (w == 0) ? int'(c101_a) : int'(c101_b);
                c0 = (w == 0) ? int'(c100_a) : int'(c100_b);
                break;
            end
            @(negedge clk);
        end
        drive(w, 1'b0, d, l);
    endtask

    initial begin
        logic [63:0] bits;
        int nb, dn, c1, c0;
        rst = 1'b1;
        start_a = 0; start_b = 0; data_a = '0; data_b = '0; len_a = '0; len_b = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        cmp("rst_valid", 0, int'(valid_a), 0);
        cmp("rst_cnt101", 0, int'(c101_a), 0);

        go(0, 64'b101101, 6, 0, bits, nb, dn, c1, c0);
        cmp("p101_bits", 0, int'(bits[31:0]), 32'b101101);
        cmp("p101_nbits", 0, nb, 6);
        cmp("p101_done_at", 0, dn, 7);
        cmp("p101_c101", 0, c1, 2);
        cmp("p101_c100", 0, c0, 0);

        go(0, 64'b100100, 6, 1, bits, nb, dn, c1, c0);
        cmp("p100_bits", 0, int'(bits[31:0]), 32'b100100);
        cmp("p100_done_at", 0, dn, 7);
        cmp("p100_c100", 0, c0, 2);
        cmp("p100_c101", 0, c1, 0);

        go(0, 64'b10101, 5, 0, bits, nb, dn, c1, c0);
        cmp("ovl_c101", 0, c1, 2);
        go(0, 64'b10, 2, 0, bits, nb, dn, c1, c0);
        cmp("len2_c101", 0, c1, 0);
        cmp("len2_c100", 0, c0, 0);
        go(0, 64'h3, 0, 0, bits, nb, dn, c1, c0);
        cmp("len0_done_at", 0, dn, 1);
        cmp("len0_nbits", 0, nb, 0);

        go(1, 64'hAAA, 15, 0, bits, nb, dn, c1, c0);
        cmp("clamp_nbits", 1, nb, 12);
        cmp("clamp_bits", 1, int'(bits[31:0]), 32'hAAA);
        cmp("clamp_done_at", 1, dn, 13);
        cmp("sat_c101", 1, c1, 3);
        cmp("sat_c100", 1, c0, 0);

        // Reset lands in cycle T0+4 of an 8-bit stream.
        @(negedge clk);
        drive(0, 1'b1, 64'hB5, 8);
        @(negedge clk);
        drive(0, 1'b0, 64'hB5, 8);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        cmp("abort_valid", 0, int'(valid_a), 0);
        cmp("abort_busy", 0, int'(busy_a), 0);
        cmp("abort_done", 0, int'(done_a), 0);
        cmp("abort_c101", 0, int'(c101_a), 0);
        go(0, 64'b1001, 4, 0, bits, nb, dn, c1, c0);
        cmp("after_rst_done_at", 0, dn, 5);
        cmp("after_rst_bits", 0, int'(bits[31:0]), 32'b1001);

        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            start_a = ($urandom % 4 == 0);
            data_a  = 42'({$urandom, $urandom});
            len_a   = 6'($urandom_range(0, 63));
            start_b = ($urandom % 3 == 0);
            data_b  = 12'($urandom);
            len_b   = 6'($urandom_range(0, 63));
            rst     = ($urandom % 150 == 0);
        end
        @(negedge clk);
        start_a = 0; start_b = 0; rst = 0;
        repeat (60) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
